// File: rtl/serial_responder.sv
// rtl/serial_responder.sv - target end of the serial shift link: deserialises one word per frame, returns a preloaded word
module serial_responder #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLKB,
    input  logic             RST,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             rx,
    output logic             tx,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             rx_valid,
    input  logic             rx_ack,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, rx_sync_q;
    logic                   sclk_prev, cs_prev;
    logic [WIDTH-1:0]       tx_sr;
    logic [WIDTH-2:0]       rx_sr;
    logic [CW-1:0]          bit_cnt;

    logic sclk_s, cs_s, rx_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic last_bit, word_done;
    logic [WIDTH-1:0] rx_next;

    // Idle presets match the link's idle levels so reset release never looks like an edge.
    always_ff @(posedge CLKB or negedge RST) begin
        if (!RST) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            rx_sync_q <= '1;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            rx_sync_q <= {rx_sync_q[SYNC_STAGES-2:0], rx};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            cs_prev   <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign rx_s      = rx_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign last_bit  = (bit_cnt == CW'(WIDTH - 1));
    assign rx_next   = {rx_sr, rx_s};
    assign word_done = (state == SHIFT) && !cs_rise && sclk_rise && last_bit;

    always_ff @(posedge CLKB or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = SHIFT;
            SHIFT: begin
                if (cs_rise)                    state_nxt = IDLE;
                else if (sclk_rise && last_bit) state_nxt = HOLD;
            end
            HOLD:    if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        busy = (state != IDLE);
        if (state == SHIFT) tx = tx_sr[WIDTH-1];
    end

    always_ff @(posedge CLKB or negedge RST) begin
        if (!RST) begin
            tx_sr     <= '0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            data_out  <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (state == IDLE && cs_fall) begin
                tx_sr   <= data_in;
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                if (cs_rise) begin
                    frame_err <= 1'b1;
                end else begin
                    if (sclk_rise) begin
                        rx_sr   <= rx_next[WIDTH-2:0];
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                    if (sclk_fall) tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
                end
            end
            // An ack landing on the completion cycle consumes the old word, so the new one stays valid.
            if (word_done) begin
                data_out <= rx_next;
                rx_valid <= 1'b1;
                overrun  <= rx_valid & ~rx_ack;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/serial_responder.md
Name: serial_responder

Overview:
- Target end of the WIDTH-bit serial shift link: the far side of the master shift engine.
- Samples a master-driven shift clock, frame select and data line, all asynchronous to CLKB.
- Deserialises one word per frame, MSB first, while returning a preloaded response word on tx.
- Hands received words to local logic with a valid/ack handshake and flags framing and overrun errors.

Parameters:
WIDTH, 32, word length in bits per frame (≥2)
SYNC_STAGES, 2, synchroniser flops on sclk, cs_n, rx (≥2)

Ports:
CLKB  input  1  system clock; all state on posedge
RST  input  1  asynchronous, active-low reset
sclk  input  1  master shift clock, async to CLKB; master changes rx on falling edge, responder samples on rising edge
cs_n  input  1  frame select, active-low, async
rx  input  1  serial data from master
tx  output  1  serial data to master
data_in  input  WIDTH  response word; captured at frame start
data_out  output  WIDTH  last complete received word
rx_valid  output  1  data_out holds an unconsumed word
rx_ack  input  1  local logic consumed data_out
busy  output  1  frame in progress
frame_err  output  1  one-cycle pulse: frame ended short
overrun  output  1  one-cycle pulse: word completed while rx_valid still high

Behaviour:
- Reset (RST low, async): data_out=0, rx_valid=0, tx=1, busy=0, frame_err=0, overrun=0; bit counter=0; state IDLE; synchroniser flops preset to sclk=0, cs_n=1, rx=1.
- sclk, cs_n, rx pass through SYNC_STAGES flops, then one edge-detect register. Edge reaches the FSM SYNC_STAGES+1 cycles after the pin change.
- Timing limit: sclk high and low ≥ SYNC_STAGES+2 CLKB cycles each. cs_n setup to the first sclk rise: same limit.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE, cs_n falling edge:
  - tx shift register <= data_in; tx = data_in[WIDTH-1].
  - Bit counter=0; busy=1; go to SHIFT.
- SHIFT:
  - sclk rising edge: rx shift register <= {rx_sr[WIDTH-2:0], rx_sync}; counter++.
  - sclk falling edge: tx shifts left; tx shows the next bit.
  - WIDTH-th rising edge: data_out <= completed word in the same cycle; rx_valid=1; go to HOLD.
  - If rx_valid was already 1 and rx_ack is not high that cycle: overrun pulses, and data_out is overwritten by the new word.
- HOLD: further sclk edges are ignored; tx=1.
- cs_n rising edge, any state: busy=0, tx=1, go to IDLE.
  - From SHIFT with counter<WIDTH: frame_err pulses; data_out and rx_valid unchanged; partial word discarded.
- rx_ack with rx_valid=1: rx_valid clears next cycle.
- rx_ack and a word completion in the same cycle: rx_valid stays 1, data_out takes the new word, no overrun.
- rx_ack with rx_valid=0: ignored.
- cs_n falling edge outside IDLE (glitch/re-select without deselect): ignored.
- Counter width: clog2(WIDTH+1). No wrap, because the FSM leaves SHIFT at WIDTH.
- data_in is sampled only at frame start. Later changes do not affect the frame in progress.

Test Plan:
- WIDTH=8, data_in=8'hA5, master sends 8'h3C with sclk 8 CLKB high/low -> tx bits 1,0,1,0,0,1,0,1; data_out=8'h3C; rx_valid rises 3 cycles after the 8th sclk rise; busy 1 through the frame.
- RST pulsed low mid-frame after 4 bits -> all outputs return to reset values immediately (async). Next full frame 8'hFF -> data_out=8'hFF, no frame_err.
- cs_n deasserted after 5 bits of 8'h81 -> frame_err one-cycle pulse; data_out keeps the previous value; rx_valid unchanged.
- Two frames 8'h11 then 8'h22, rx_ack never asserted -> overrun pulses once at the second completion; data_out=8'h22; rx_valid=1.
- rx_ack asserted exactly on the completion cycle of 8'h22 with 8'h11 pending -> no overrun; rx_valid=1; data_out=8'h22.
- 10 sclk pulses in one frame of WIDTH=8, data_in changed mid-frame -> data_out = first 8 bits only; extra edges ignored; tx=1 after bit 8; tx bits come from the data_in value at frame start.
